// File: rtl/sys_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sys_cmd_pkg
// Shared definitions for the system command initiator:
//   - frame opcode bytes that open each UART command frame
//   - host-side command type encoding (CMD_TYPE)
//   - frame length per command type
//   - initiator FSM state encoding
//   - frame buffer layout captured on command acceptance
// -----------------------------------------------------------------------------
package sys_cmd_pkg;

    // Leading opcode byte of each frame
    localparam logic [7:0] FRM_RF_WR   = 8'hAA;
    localparam logic [7:0] FRM_RF_RD   = 8'hBB;
    localparam logic [7:0] FRM_ALU_OP  = 8'hCC;
    localparam logic [7:0] FRM_ALU_NOP = 8'hDD;

    // Host command type encoding
    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    // Frame lengths in bytes
    localparam logic [2:0] LEN_RF_WR   = 3'd3;
    localparam logic [2:0] LEN_RF_RD   = 3'd2;
    localparam logic [2:0] LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] LEN_ALU_NOP = 3'd2;

    // Initiator FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_ACK_H    = 3'd2,
        ST_ACK_L    = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Command fields captured at acceptance
    typedef struct packed {
        cmd_type_e  typ;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] fun;
    } frame_buf_t;

    // Number of bytes in the frame for a given command type
    function automatic logic [2:0] frame_len(input cmd_type_e typ);
        logic [2:0] len;
        case (typ)
            CMD_RF_WR:   len = LEN_RF_WR;
            CMD_RF_RD:   len = LEN_RF_RD;
            CMD_ALU_OP:  len = LEN_ALU_OP;
            CMD_ALU_NOP: len = LEN_ALU_NOP;
            default:     len = LEN_RF_RD;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sys_cmd_frame_sel.sv
// -----------------------------------------------------------------------------
// sys_cmd_frame_sel
// Combinational byte selector: picks byte <idx> of the command frame held in
// the frame buffer and flags whether it is the final byte of that frame.
// Ports:
//   frm       in   captured command fields (type, addr, wdata, opa, opb, fun)
//   idx       in   byte position within the frame (0..3)
//   sel_byte  out  frame byte at position idx
//   sel_last  out  1 when idx addresses the last byte of the frame
// -----------------------------------------------------------------------------
module sys_cmd_frame_sel
    import sys_cmd_pkg::*;
(
    input  frame_buf_t  frm,
    input  logic [1:0]  idx,
    output logic [7:0]  sel_byte,
    output logic        sel_last
);

    // Byte multiplexer; 4-bit fields are zero-extended onto the wire
    always_comb begin
        sel_byte = 8'h00;
        case (frm.typ)
            CMD_RF_WR: begin
                case (idx)
                    2'd0:    sel_byte = FRM_RF_WR;
                    2'd1:    sel_byte = {4'h0, frm.addr};
                    2'd2:    sel_byte = frm.wdata;
                    default: sel_byte = 8'h00;
                endcase
            end
            CMD_RF_RD: begin
                case (idx)
                    2'd0:    sel_byte = FRM_RF_RD;
                    2'd1:    sel_byte = {4'h0, frm.addr};
                    default: sel_byte = 8'h00;
                endcase
            end
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    sel_byte = FRM_ALU_OP;
                    2'd1:    sel_byte = frm.opa;
                    2'd2:    sel_byte = frm.opb;
                    2'd3:    sel_byte = {4'h0, frm.fun};
                    default: sel_byte = 8'h00;
                endcase
            end
            CMD_ALU_NOP: begin
                case (idx)
                    2'd0:    sel_byte = FRM_ALU_NOP;
                    2'd1:    sel_byte = {4'h0, frm.fun};
                    default: sel_byte = 8'h00;
                endcase
            end
            default: sel_byte = 8'h00;
        endcase
    end

    // Last-byte flag from the per-type frame length
    always_comb begin
        sel_last = ({1'b0, idx} == (frame_len(frm.typ) - 3'd1));
    end

endmodule

// File: rtl/sys_cmd_initiator.sv
// -----------------------------------------------------------------------------
// sys_cmd_initiator
// Host-side initiator for the system command protocol. Accepts one command per
// CMD_VLD/CMD_RDY handshake, serializes it byte by byte to a UART transmitter
// (strobe, wait for busy high, wait for busy low), then waits for the single
// response byte unless the command is an RF write.
//
// Optional feature (macro SYS_CMD_RSP_TIMEOUT_EN): a response timer that ends
// the wait after TIMEOUT_CYCLES cycles with RSP_ERR=1 and RSP_DATA=0x00.
// Without the macro no timer is built and RSP_ERR is constant 0.
//
// Parameters:
//   TIMEOUT_CYCLES  response wait limit in clock cycles (timer builds only)
//   TO_W            timer width, 2**TO_W > TIMEOUT_CYCLES
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   CMD_VLD/CMD_RDY               command handshake
//   CMD_TYPE/ADDR/WDATA/OPA/OPB/FUN  command fields
//   TX_P_DATA/TX_D_VLD/TX_BUSY    UART transmitter interface
//   RX_P_DATA/RX_D_VLD            UART receiver interface
//   RSP_DATA/RSP_VLD/RSP_ERR      completion report
// -----------------------------------------------------------------------------
module sys_cmd_initiator
    import sys_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VLD,
    input  logic [1:0] CMD_TYPE,
    input  logic [3:0] CMD_ADDR,
    input  logic [7:0] CMD_WDATA,
    input  logic [7:0] CMD_OPA,
    input  logic [7:0] CMD_OPB,
    input  logic [3:0] CMD_FUN,
    output logic       CMD_RDY,
    output logic [7:0] TX_P_DATA,
    output logic       TX_D_VLD,
    input  logic       TX_BUSY,
    input  logic [7:0] RX_P_DATA,
    input  logic       RX_D_VLD,
    output logic [7:0] RSP_DATA,
    output logic       RSP_VLD,
    output logic       RSP_ERR
);

    state_e     state_r, state_nxt_s;
    logic [1:0] idx_r, idx_nxt_s;
    frame_buf_t frm_r;
    logic       buf_ld_s;
    logic       rdy_r;
    logic [7:0] tx_data_r, tx_data_nxt_s;
    logic       tx_vld_r, tx_vld_nxt_s;
    logic [7:0] rsp_data_r, rsp_data_nxt_s;
    logic       rsp_vld_r, rsp_vld_nxt_s;
    logic [7:0] sel_byte_s;
    logic       sel_last_s;

`ifdef SYS_CMD_RSP_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_r;
    logic            to_clr_s;
    logic            to_hit_s;
    logic            rsp_err_r, rsp_err_nxt_s;
`endif

    sys_cmd_frame_sel u_frame_sel (
        .frm      (frm_r),
        .idx      (idx_r),
        .sel_byte (sel_byte_s),
        .sel_last (sel_last_s)
    );

`ifdef SYS_CMD_RSP_TIMEOUT_EN
    // Limit is reached when the counter shows TIMEOUT_CYCLES-1 during the
    // final WAIT_RSP cycle, so the exit happens on the TIMEOUT_CYCLES-th edge
    always_comb begin
        to_hit_s = (to_cnt_r == TO_LIMIT);
    end
`endif

    // Next-state, frame index and registered-output next values
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        buf_ld_s       = 1'b0;
        tx_data_nxt_s  = tx_data_r;
        tx_vld_nxt_s   = 1'b0;
        rsp_data_nxt_s = rsp_data_r;
        rsp_vld_nxt_s  = 1'b0;
`ifdef SYS_CMD_RSP_TIMEOUT_EN
        rsp_err_nxt_s  = 1'b0;
        to_clr_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (CMD_VLD && rdy_r) begin
                    buf_ld_s    = 1'b1;
                    idx_nxt_s   = 2'd0;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!TX_BUSY) begin
                    tx_data_nxt_s = sel_byte_s;
                    tx_vld_nxt_s  = 1'b1;
                    state_nxt_s   = ST_ACK_H;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_ACK_H: begin
                if (TX_BUSY) begin
                    state_nxt_s = ST_ACK_L;
                end else begin
                    state_nxt_s = ST_ACK_H;
                end
            end
            ST_ACK_L: begin
                if (TX_BUSY) begin
                    state_nxt_s = ST_ACK_L;
                end else if (!sel_last_s) begin
                    idx_nxt_s   = idx_r + 2'd1;
                    state_nxt_s = ST_SEND;
                end else if (frm_r.typ == CMD_RF_WR) begin
                    // No response: report completion, RSP_DATA left as is
                    rsp_vld_nxt_s = 1'b1;
                    state_nxt_s   = ST_DONE;
                end else begin
`ifdef SYS_CMD_RSP_TIMEOUT_EN
                    to_clr_s    = 1'b1;
`endif
                    state_nxt_s = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // Data beats the timeout when both happen in the same cycle
                if (RX_D_VLD) begin
                    rsp_data_nxt_s = RX_P_DATA;
                    rsp_vld_nxt_s  = 1'b1;
                    state_nxt_s    = ST_DONE;
                end
`ifdef SYS_CMD_RSP_TIMEOUT_EN
                else if (to_hit_s) begin
                    rsp_data_nxt_s = 8'h00;
                    rsp_vld_nxt_s  = 1'b1;
                    rsp_err_nxt_s  = 1'b1;
                    state_nxt_s    = ST_DONE;
                end
`endif
                else begin
                    state_nxt_s = ST_WAIT_RSP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, frame buffer and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            idx_r      <= 2'd0;
            frm_r      <= '0;
            rdy_r      <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_vld_r   <= 1'b0;
            rsp_data_r <= 8'h00;
            rsp_vld_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            rdy_r      <= (state_nxt_s == ST_IDLE);
            tx_data_r  <= tx_data_nxt_s;
            tx_vld_r   <= tx_vld_nxt_s;
            rsp_data_r <= rsp_data_nxt_s;
            rsp_vld_r  <= rsp_vld_nxt_s;
            if (buf_ld_s) begin
                frm_r <= '{typ:   cmd_type_e'(CMD_TYPE),
                           addr:  CMD_ADDR,
                           wdata: CMD_WDATA,
                           opa:   CMD_OPA,
                           opb:   CMD_OPB,
                           fun:   CMD_FUN};
            end
        end
    end

`ifdef SYS_CMD_RSP_TIMEOUT_EN
    // Response timer: cleared on entry to WAIT_RSP, counts while waiting
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_r  <= '0;
            rsp_err_r <= 1'b0;
        end else begin
            rsp_err_r <= rsp_err_nxt_s;
            if (to_clr_s) begin
                to_cnt_r <= '0;
            end else if (state_r == ST_WAIT_RSP) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end

    assign RSP_ERR = rsp_err_r;
`else
    // No timer: an error can never be reported. The timer parameters only
    // feed this constant so both builds keep one parameter list.
    assign RSP_ERR = (TIMEOUT_CYCLES < 0) && (TO_W < 0);
`endif

    assign CMD_RDY   = rdy_r;
    assign TX_P_DATA = tx_data_r;
    assign TX_D_VLD  = tx_vld_r;
    assign RSP_DATA  = rsp_data_r;
    assign RSP_VLD   = rsp_vld_r;

endmodule

// File: tb/tb_sys_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_sys_cmd_initiator
// Directed self-checking bench for sys_cmd_initiator. A UART TX model holds
// TX_BUSY high for 10 cycles after each strobe; the bench plays the responder
// by driving RX bytes directly. Inputs are driven and outputs checked 1 ns
// after the falling clock edge; monitors record strobes on the falling edge.
// -----------------------------------------------------------------------------
module tb_sys_cmd_initiator;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VLD;
    logic [1:0] CMD_TYPE;
    logic [3:0] CMD_ADDR;
    logic [7:0] CMD_WDATA;
    logic [7:0] CMD_OPA;
    logic [7:0] CMD_OPB;
    logic [3:0] CMD_FUN;
    logic       CMD_RDY;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RSP_DATA;
    logic       RSP_VLD;
    logic       RSP_ERR;

    sys_cmd_initiator #(.TIMEOUT_CYCLES(50), .TO_W(16)) dut (
        .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_OPA(CMD_OPA),
        .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN), .CMD_RDY(CMD_RDY),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RSP_DATA(RSP_DATA),
        .RSP_VLD(RSP_VLD), .RSP_ERR(RSP_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // UART TX model
    int   busy_cnt = 0;
    logic hold_busy = 1'b0;
    always @(posedge CLK) begin
        if (RST)               busy_cnt <= 0;
        else if (TX_D_VLD)     busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign TX_BUSY = (busy_cnt != 0) || hold_busy;

    // Monitors
    logic [7:0] tx_q[$];
    int   tx_first_cyc = 0, last_tx_cyc = 0, fall_cyc = 0;
    int   rsp_cnt = 0, rsp_cyc = 0, overlap_cnt = 0, busy_viol = 0;
    logic [7:0] rsp_data_seen = 8'h00;
    logic rsp_err_seen = 1'b0;
    logic prev_busy = 1'b0;
    always @(negedge CLK) begin
        if (TX_D_VLD) begin
            if (tx_q.size() == 0) tx_first_cyc = cyc;
            tx_q.push_back(TX_P_DATA);
            last_tx_cyc = cyc;
            if (TX_BUSY) busy_viol++;
        end
        if (RSP_VLD) begin
            if (rsp_cnt == 0) begin
                rsp_cyc       = cyc;
                rsp_data_seen = RSP_DATA;
                rsp_err_seen  = RSP_ERR;
            end
            rsp_cnt++;
            if (TX_D_VLD) overlap_cnt++;
        end
        if (prev_busy && !TX_BUSY) fall_cyc = cyc;
        prev_busy = TX_BUSY;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int acc_cyc = 0, rx_edge = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        tx_q.delete();
        rsp_cnt = 0;
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                            input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
        int k = 0;
        while (!CMD_RDY && k < 100) begin tick(); k++; end
        check_eq("cmd_rdy_wait", CMD_RDY, 1);
        CMD_VLD = 1'b1; CMD_TYPE = t; CMD_ADDR = a; CMD_WDATA = wd;
        CMD_OPA = oa; CMD_OPB = ob; CMD_FUN = f;
        acc_cyc = cyc + 1;
        tick();
        // Scramble fields: the captured frame must not follow them
        CMD_VLD = 1'b0; CMD_TYPE = ~t; CMD_ADDR = ~a; CMD_WDATA = ~wd;
        CMD_OPA = ~oa; CMD_OPB = ~ob; CMD_FUN = ~f;
    endtask

    task automatic wait_tx_done(input string tag, input int n);
        int k = 0;
        while (!(tx_q.size() >= n && fall_cyc > last_tx_cyc) && k < 500) begin tick(); k++; end
        check_eq({tag, "_txdone"}, (tx_q.size() >= n && fall_cyc > last_tx_cyc), 1);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int k = 0;
        while (rsp_cnt == 0 && k < budget) begin tick(); k++; end
        check_eq({tag, "_rsp_seen"}, (rsp_cnt != 0), 1);
    endtask

    task automatic drive_rx(input logic [7:0] d);
        RX_P_DATA = d; RX_D_VLD = 1'b1;
        rx_edge = cyc + 1;
        tick();
        RX_D_VLD = 1'b0; RX_P_DATA = 8'h00;
    endtask

    task automatic check_frame(input string tag, input int n, input logic [31:0] exp);
        check_eq({tag, "_len"}, tx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_b%0d", tag, i),
                     (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF,
                     {24'h0, exp[8*(n-1-i) +: 8]});
        end
    endtask

    // Pulse width and return to ready after a completion
    task automatic check_after_rsp(input string tag);
        tick();
        check_eq({tag, "_rsp_pulse"}, RSP_VLD, 0);
        check_eq({tag, "_rdy_back"}, CMD_RDY, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; CMD_VLD = 1'b0; CMD_TYPE = 2'd0; CMD_ADDR = 4'h0;
        CMD_WDATA = 8'h00; CMD_OPA = 8'h00; CMD_OPB = 8'h00; CMD_FUN = 4'h0;
        RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
        tick(); tick(); tick();

        // Reset values
        check_eq("rst_cmd_rdy", CMD_RDY, 0);
        check_eq("rst_tx_vld", TX_D_VLD, 0);
        check_eq("rst_tx_data", TX_P_DATA, 8'h00);
        check_eq("rst_rsp_vld", RSP_VLD, 0);
        check_eq("rst_rsp_data", RSP_DATA, 8'h00);
        check_eq("rst_rsp_err", RSP_ERR, 0);
        RST = 1'b0;
        tick();
        check_eq("rst_rdy_after", CMD_RDY, 1);

        // RF_WR addr 5 data 3C: no response wait
        clear_mon();
        send_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        check_eq("wr_busy_rdy", CMD_RDY, 0);
        wait_tx_done("wr", 3);
        wait_rsp("wr", 20);
        check_frame("wr", 3, 32'h00AA053C);
        check_eq("wr_first_lat", tx_first_cyc, acc_cyc + 1);
        check_eq("wr_rsp_lat", rsp_cyc, fall_cyc + 1);
        check_eq("wr_rsp_err", rsp_err_seen, 0);
        check_eq("wr_rsp_data", rsp_data_seen, 8'h00);
        check_after_rsp("wr");

        // RF_RD addr 2, reply 7E
        clear_mon();
        send_cmd(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done("rd", 2);
        tick(); tick(); tick();
        check_eq("rd_no_early_rsp", rsp_cnt, 0);
        drive_rx(8'h7E);
        check_frame("rd", 2, 32'h0000BB02);
        check_eq("rd_rsp_seen", rsp_cnt, 1);
        check_eq("rd_rsp_lat", rsp_cyc, rx_edge);
        check_eq("rd_rsp_data", rsp_data_seen, 8'h7E);
        check_eq("rd_rsp_err", rsp_err_seen, 0);
        check_after_rsp("rd");

        // ALU_OP 12,34,fun 0; spurious RX 99 while in SEND
        clear_mon();
        send_cmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0);
        drive_rx(8'h99);
        wait_tx_done("alu", 4);
        tick(); tick();
        check_eq("alu_spurious_drop", rsp_cnt, 0);
        drive_rx(8'h46);
        check_frame("alu", 4, 32'hCC123400);
        check_eq("alu_rsp_lat", rsp_cyc, rx_edge);
        check_eq("alu_rsp_data", rsp_data_seen, 8'h46);
        check_eq("alu_rsp_err", rsp_err_seen, 0);
        check_after_rsp("alu");

        // ALU_NOP fun 3 with TX busy held 20 cycles; CMD_VLD pulsed mid-frame
        clear_mon();
        hold_busy = 1'b1;
        send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                CMD_VLD = 1'b1; CMD_TYPE = 2'd0; CMD_ADDR = 4'hA; CMD_WDATA = 8'h55;
            end else begin
                CMD_VLD = 1'b0;
            end
            tick();
        end
        CMD_VLD = 1'b0;
        check_eq("nop_withheld", tx_q.size(), 0);
        hold_busy = 1'b0;
        wait_tx_done("nop", 2);
        tick(); tick();
        drive_rx(8'h5A);
        check_frame("nop", 2, 32'h0000DD03);
        check_eq("nop_rsp_data", rsp_data_seen, 8'h5A);
        check_eq("nop_rsp_lat", rsp_cyc, rx_edge);
        check_after_rsp("nop");
        for (int i = 0; i < 30; i++) tick();
        check_eq("nop_ignored_cmd", tx_q.size(), 2);
        check_eq("nop_rsp_count", rsp_cnt, 1);

`ifdef SYS_CMD_RSP_TIMEOUT_EN
        // RF_RD with no reply: timeout on the 50th WAIT_RSP cycle
        clear_mon();
        send_cmd(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done("to", 2);
        wait_rsp("to", 200);
        check_eq("to_lat", rsp_cyc, fall_cyc + 51);
        check_eq("to_err", rsp_err_seen, 1);
        check_eq("to_data", rsp_data_seen, 8'h00);
        check_after_rsp("to");

        // Reply exactly at the limit: data wins
        clear_mon();
        send_cmd(2'd1, 4'h4, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done("tolim", 2);
        while (cyc < fall_cyc + 50) tick();
        check_eq("tolim_no_early", rsp_cnt, 0);
        drive_rx(8'hA5);
        check_eq("tolim_lat", rsp_cyc, fall_cyc + 51);
        check_eq("tolim_err", rsp_err_seen, 0);
        check_eq("tolim_data", rsp_data_seen, 8'hA5);
        check_after_rsp("tolim");
`endif

        // Reset after the 2nd byte of an ALU_OP frame
        clear_mon();
        send_cmd(2'd2, 4'h0, 8'h00, 8'h55, 8'h66, 4'h7);
        begin
            int k = 0;
            while (tx_q.size() < 2 && k < 200) begin tick(); k++; end
        end
        check_eq("mid_two_bytes", tx_q.size(), 2);
        RST = 1'b1;
        tick();
        check_eq("mid_rst_tx_vld", TX_D_VLD, 0);
        check_eq("mid_rst_rdy", CMD_RDY, 0);
        check_eq("mid_rst_tx_data", TX_P_DATA, 8'h00);
        check_eq("mid_rst_rsp_data", RSP_DATA, 8'h00);
        tick();
        RST = 1'b0;
        tick();
        check_eq("mid_rdy_after", CMD_RDY, 1);
        for (int i = 0; i < 20; i++) tick();
        check_eq("mid_abandoned", tx_q.size(), 2);

        // New RF_RD after the abort completes normally
        clear_mon();
        send_cmd(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_done("rd2", 2);
        tick(); tick();
        drive_rx(8'h11);
        check_frame("rd2", 2, 32'h0000BB09);
        check_eq("rd2_rsp_data", rsp_data_seen, 8'h11);
        check_after_rsp("rd2");

        // RF_WR leaves the previous response byte untouched
        clear_mon();
        send_cmd(2'd0, 4'h1, 8'h22, 8'h00, 8'h00, 4'h0);
        wait_tx_done("wr2", 3);
        wait_rsp("wr2", 20);
        check_frame("wr2", 3, 32'h00AA0122);
        check_eq("wr2_rsp_data", rsp_data_seen, 8'h11);
        check_eq("wr2_rsp_err", rsp_err_seen, 0);
        check_after_rsp("wr2");

        check_eq("tx_rsp_overlap", overlap_cnt, 0);
        check_eq("tx_while_busy", busy_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
